hazard_ctrl_gen: RTL and testbench
==================================

Name: hazard_ctrl_gen

Overview:
- Parametrised successor to the decode-stage hazard/bypass/flush logic of the pipelined core.
- Tracks in-flight destination registers in a shadow pipeline of BYP_STAGES stages.
- Generates load-use stalls for any load latency, per-source bypass selects for any number of sources and stages, a configurable-depth flush window, multi-cycle instruction stalls and sticky halt.
- Sits beside the ID stage and drives the IM_ID stall and the ID_EX kill/bypass controls.

Parameters:
- RF_ADDR_W, 4, register address width; address 0 is hard-wired zero and never hazards or bypasses.
- NUM_SRC, 2, source operands per instruction.
- BYP_STAGES, 2, in-flight stages with a bypass path; stage 1 = ID_EX, stage 2 = EX_DM, and so on.
- LOAD_LAT, 1, load data is unavailable while the load sits in stages 1..LOAD_LAT. Range 0..BYP_STAGES-1.
- FLUSH_DEPTH, 2, cycles of ID kill per flow change. Minimum 1.
- MC_CYCLES, 2, total ID occupancy of a multi-cycle instruction (MOVC/LWI). Minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src_addr  in  NUM_SRC*RF_ADDR_W  source addresses; src i in bits [i*W +: W]
- id_src_re  in  NUM_SRC  source i is read
- id_dst_addr  in  RF_ADDR_W  destination address
- id_we  in  1  instruction writes RF
- id_is_load  in  1  instruction is a load
- id_multicycle  in  1  instruction needs MC_CYCLES in ID
- id_hlt  in  1  halt instruction
- flow_change  in  1  taken branch/jump resolved in EX this cycle
- stall_IM_ID  out  1  hold the IM_ID register (combinational)
- flush  out  1  ID instruction is killed this cycle (combinational)
- load_use_hazard  out  1  combinational
- issue_ID_EX  out  1  registered; valid instruction entered EX
- byp_ID_EX  out  NUM_SRC*BYP_STAGES  registered; one-hot-or-zero per source; src i stage k in bit [i*BYP_STAGES + k-1]
- halted  out  1  registered; sticky halt

Behaviour:
- Reset clears all shadow stages, counters, issue_ID_EX, byp_ID_EX and halted, and places the FSM in RUN. Reset overrides all inputs, including in the middle of MC_WAIT or a flush window.
- Shadow pipe: each stage holds {v, we, dst, ld}. It shifts every cycle and is never stalled. Stage 1 loads the ID instruction only if it issues; otherwise stage 1 loads v=0.
- Match condition for source i at stage k: id_src_re[i], src != 0, stage k v & we, and dst == src.
- Load-use hazard: a match at any stage k <= LOAD_LAT with ld=1, while id_valid and not flush. The ID instruction is not issued (bubble), stall_IM_ID=1, and the pipe advances. The hazard is re-evaluated next cycle.
- Bypass: for each source, select the smallest (youngest) matching k, and register the select into byp_ID_EX on issue. When not issuing, byp_ID_EX becomes 0. No match means no bit set; the value comes from RF via write-through.
- Flush window:
  - flow_change at cycle t sets a down-counter to FLUSH_DEPTH-1.
  - flush = flow_change | (counter != 0).
  - A flow_change arriving inside the window reloads the counter.
  - A flushed instruction never issues, never starts MC_WAIT and never halts.
- Priority: rst > flush > halted > load-use > multicycle.
- FSM:
  - RUN: issue when id_valid and none of flush, halted or hazard. If the issued instruction has id_multicycle and MC_CYCLES > 1, go to MC_WAIT with the counter set to MC_CYCLES-1 and stall_IM_ID=1. The instruction issues once, in its first cycle.
  - MC_WAIT: stall_IM_ID=1, no issue. The counter decrements each cycle. Return to RUN when it reaches 0, with stall released in that cycle. A flush during MC_WAIT aborts to RUN immediately.
  - HALTED: entered the cycle after a non-flushed id_hlt issues. Sticky until rst. stall_IM_ID=1 and no further issue.
- issue_ID_EX equals the stage-1 valid bit.

Test Plan:
- Load R3 then ADD R4,R3,R1 back-to-back, LOAD_LAT=1: one bubble with load_use_hazard=1 and stall_IM_ID=1 for 1 cycle; the ADD then issues with byp src0 stage 2 = 1.
- ADD R5 followed by SUB R6,R5,R5: no stall; byp_ID_EX = 4'b0101 (both sources, stage 1).
- Write R2 at stages 1 and 2 simultaneously, consumer reads R2: only the stage-1 bit is set. Consumer of R0 when the in-flight dst is R0: no bypass and no hazard.
- flow_change pulse with FLUSH_DEPTH=2: flush=1 for exactly 2 cycles; id_hlt inside the window is ignored and halted stays 0. A second flow_change in cycle 2 extends flush to 3 cycles total.
- id_multicycle with MC_CYCLES=3: issue once, then stall_IM_ID high 2 more cycles. rst in the 2nd cycle returns to RUN with all outputs 0.
- Non-flushed id_hlt: halted=1 next cycle, stall_IM_ID held, issue_ID_EX stays 0 until rst.

Source files
------------

// File: rtl/hazard_ctrl_gen.sv
// Decode-stage hazard control: load-use stall, per-source bypass select, flush window,
// multi-cycle ID occupancy and sticky halt, driven from a never-stalled shadow pipe.
module hazard_ctrl_gen #(
  parameter int unsigned RF_ADDR_W   = 4,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned BYP_STAGES  = 2,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned MC_CYCLES   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*RF_ADDR_W-1:0]  id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_re,
  input  logic [RF_ADDR_W-1:0]          id_dst_addr,
  input  logic                          id_we,
  input  logic                          id_is_load,
  input  logic                          id_multicycle,
  input  logic                          id_hlt,
  input  logic                          flow_change,
  output logic                          stall_IM_ID,
  output logic                          flush,
  output logic                          load_use_hazard,
  output logic                          issue_ID_EX,
  output logic [NUM_SRC*BYP_STAGES-1:0] byp_ID_EX,
  output logic                          halted
);

  localparam int unsigned FcW  = $clog2(FLUSH_DEPTH + 1);
  localparam int unsigned McW  = $clog2(MC_CYCLES + 1);
  localparam int unsigned SelW = NUM_SRC * BYP_STAGES;
  // Stages still waiting on load data.
  localparam logic [BYP_STAGES-1:0] LdMask = BYP_STAGES'((64'd1 << LOAD_LAT) - 64'd1);

  typedef enum logic [1:0] {StRun, StMcWait, StHalted} state_e;

  state_e         state_q, state_d;
  logic [FcW-1:0] fc_q, fc_d;
  logic [McW-1:0] mc_q, mc_d;

  // Shadow pipe; index 0 is stage 1 (ID_EX).
  logic [BYP_STAGES-1:0] sh_v_q, sh_we_q, sh_ld_q;
  logic [RF_ADDR_W-1:0]  sh_dst_q [BYP_STAGES];

  logic [SelW-1:0]       match, byp_sel, byp_q;
  logic [BYP_STAGES-1:0] ld_pend;
  logic [RF_ADDR_W-1:0]  src;
  logic                  load_hit, issue;

  assign ld_pend = sh_ld_q & LdMask;

  always_comb begin
    match    = '0;
    byp_sel  = '0;
    load_hit = 1'b0;
    src      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = id_src_addr[i*RF_ADDR_W +: RF_ADDR_W];
      for (int k = 0; k < BYP_STAGES; k++) begin
        match[i*BYP_STAGES + k] = id_src_re[i] && (src != '0) && sh_v_q[k] && sh_we_q[k]
                                  && (sh_dst_q[k] == src);
        if (match[i*BYP_STAGES + k] && ld_pend[k]) load_hit = 1'b1;
      end
      // Walk oldest to youngest so the youngest match is left standing.
      for (int k = BYP_STAGES - 1; k >= 0; k--) begin
        if (match[i*BYP_STAGES + k]) begin
          for (int j = 0; j < BYP_STAGES; j++) byp_sel[i*BYP_STAGES + j] = 1'b0;
          byp_sel[i*BYP_STAGES + k] = 1'b1;
        end
      end
    end
  end

  assign flush           = flow_change | (fc_q != '0);
  assign halted          = (state_q == StHalted);
  assign load_use_hazard = (state_q == StRun) & id_valid & ~flush & load_hit;
  assign issue           = (state_q == StRun) & id_valid & ~flush & ~load_hit;

  always_comb begin
    fc_d = fc_q;
    if (flow_change) begin
      fc_d = FcW'(FLUSH_DEPTH - 1);
    end else if (fc_q != '0) begin
      fc_d = fc_q - FcW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    mc_d        = mc_q;
    stall_IM_ID = load_use_hazard;
    unique case (state_q)
      StRun: begin
        if (issue && id_hlt) begin
          state_d = StHalted;
        end else if (issue && id_multicycle && (MC_CYCLES > 1)) begin
          state_d     = StMcWait;
          mc_d        = McW'(MC_CYCLES - 1);
          stall_IM_ID = 1'b1;
        end
      end
      StMcWait: begin
        if (flush) begin
          state_d = StRun;
          mc_d    = '0;
        end else begin
          mc_d = mc_q - McW'(1);
          // Last occupancy cycle releases IM_ID so the next instruction loads.
          if (mc_q == McW'(1)) state_d = StRun;
          else                 stall_IM_ID = 1'b1;
        end
      end
      StHalted: stall_IM_ID = ~flush;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      fc_q    <= '0;
      mc_q    <= '0;
      sh_v_q  <= '0;
      sh_we_q <= '0;
      sh_ld_q <= '0;
      byp_q   <= '0;
      for (int k = 0; k < BYP_STAGES; k++) sh_dst_q[k] <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      mc_q    <= mc_d;
      for (int k = BYP_STAGES - 1; k >= 1; k--) begin
        sh_v_q[k]   <= sh_v_q[k-1];
        sh_we_q[k]  <= sh_we_q[k-1];
        sh_ld_q[k]  <= sh_ld_q[k-1];
        sh_dst_q[k] <= sh_dst_q[k-1];
      end
      sh_v_q[0]   <= issue;
      sh_we_q[0]  <= issue & id_we;
      sh_ld_q[0]  <= issue & id_is_load;
      sh_dst_q[0] <= issue ? id_dst_addr : '0;
      byp_q       <= issue ? byp_sel : '0;
    end
  end

  assign issue_ID_EX = sh_v_q[0];
  assign byp_ID_EX   = byp_q;

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Bench for hazard_ctrl_gen: per-scenario step tables; combinational outputs checked in the
// step's own cycle, registered outputs popped from an expectation queue after the edge.
module tb_hazard_ctrl_gen;

  logic       clk, rst, id_valid, id_we, id_is_load, id_multicycle, id_hlt, flow_change;
  logic [7:0] id_src_addr;
  logic [1:0] id_src_re;
  logic [3:0] id_dst_addr;
  logic       stall_IM_ID, flush, load_use_hazard, issue_ID_EX, halted;
  logic [3:0] byp_ID_EX;

  typedef struct packed {
    logic       r, fc, v;
    logic [3:0] s0, s1;
    logic [1:0] re;
    logic [3:0] dst;
    logic       we, ld, mc, hlt;
  } stim_t;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [5:0] exp_q[$];

  hazard_ctrl_gen #(
    .RF_ADDR_W  (4),
    .NUM_SRC    (2),
    .BYP_STAGES (2),
    .LOAD_LAT   (1),
    .FLUSH_DEPTH(2),
    .MC_CYCLES  (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_src_addr    (id_src_addr),
    .id_src_re      (id_src_re),
    .id_dst_addr    (id_dst_addr),
    .id_we          (id_we),
    .id_is_load     (id_is_load),
    .id_multicycle  (id_multicycle),
    .id_hlt         (id_hlt),
    .flow_change    (flow_change),
    .stall_IM_ID    (stall_IM_ID),
    .flush          (flush),
    .load_use_hazard(load_use_hazard),
    .issue_ID_EX    (issue_ID_EX),
    .byp_ID_EX      (byp_ID_EX),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(logic v, logic [3:0] s0, logic [3:0] s1, logic [1:0] re,
                               logic [3:0] dst, logic we, logic ld, logic mc, logic hlt,
                               logic fc, logic r);
    stim_t t;
    t.v = v; t.s0 = s0; t.s1 = s1; t.re = re; t.dst = dst; t.we = we; t.ld = ld;
    t.mc = mc; t.hlt = hlt; t.fc = fc; t.r = r;
    return t;
  endfunction

  task automatic drive(input stim_t t);
    rst           = t.r;
    flow_change   = t.fc;
    id_valid      = t.v;
    id_src_addr   = {t.s1, t.s0};
    id_src_re     = t.re;
    id_dst_addr   = t.dst;
    id_we         = t.we;
    id_is_load    = t.ld;
    id_multicycle = t.mc;
    id_hlt        = t.hlt;
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    drive('0);
    rst = 1'b1; id_valid = 1'b1; id_hlt = 1'b1; id_multicycle = 1'b1; id_we = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (issue_ID_EX !== 1'b0) $display("FAIL reset issue_ID_EX: got %b want 0", issue_ID_EX);
    else n_pass++;
    n_total++;
    if (byp_ID_EX !== 4'b0000) $display("FAIL reset byp_ID_EX: got %b want 0000", byp_ID_EX);
    else n_pass++;
    n_total++;
    if (halted !== 1'b0) $display("FAIL reset halted: got %b want 0", halted);
    else n_pass++;
    drive('0);
    #1;
    n_total++;
    if ({stall_IM_ID, flush, load_use_hazard} !== 3'b000)
      $display("FAIL reset comb: stall/flush/luh got %b want 000",
               {stall_IM_ID, flush, load_use_hazard});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({issue_ID_EX, byp_ID_EX, halted} !== 6'b000000)
      $display("FAIL reset idle reg: got %b want 000000", {issue_ID_EX, byp_ID_EX, halted});
    else n_pass++;
  endtask

  // ex = {stall, flush, luh, next issue, next byp[3:0], next halted}
  task automatic test_load_use();
    stim_t st[4]; logic [8:0] ex[4]; logic [5:0] e;
    st[0] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd3, Y, Y, N, N, N, N); ex[0] = 9'b000_1_0000_0;
    st[1] = mk(Y, 4'd3, 4'd1, 2'b11, 4'd4, Y, N, N, N, N, N); ex[1] = 9'b101_0_0000_0;
    st[2] = mk(Y, 4'd3, 4'd1, 2'b11, 4'd4, Y, N, N, N, N, N); ex[2] = 9'b000_1_0010_0;
    st[3] = mk(N, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[3] = 9'b000_0_0000_0;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      drive(st[s]);
      exp_q.push_back(ex[s][5:0]);
      #1;
      n_total++;
      if ({stall_IM_ID, flush, load_use_hazard} !== ex[s][8:6])
        $display("FAIL load_use comb step %0d: stall/flush/luh got %b want %b", s,
                 {stall_IM_ID, flush, load_use_hazard}, ex[s][8:6]);
      else n_pass++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({issue_ID_EX, byp_ID_EX, halted} !== e)
        $display("FAIL load_use reg step %0d: issue/byp/halted got %b want %b", s,
                 {issue_ID_EX, byp_ID_EX, halted}, e);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    stim_t st[9]; logic [8:0] ex[9]; logic [5:0] e;
    st[0] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd5, Y, N, N, N, N, N); ex[0] = 9'b000_1_0000_0;
    st[1] = mk(Y, 4'd5, 4'd5, 2'b11, 4'd6, Y, N, N, N, N, N); ex[1] = 9'b000_1_0101_0;
    st[2] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd2, Y, N, N, N, N, N); ex[2] = 9'b000_1_0000_0;
    st[3] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd2, Y, N, N, N, N, N); ex[3] = 9'b000_1_0000_0;
    st[4] = mk(Y, 4'd2, 4'd2, 2'b11, 4'd0, Y, Y, N, N, N, N); ex[4] = 9'b000_1_0101_0;
    st[5] = mk(Y, 4'd0, 4'd0, 2'b11, 4'd7, Y, N, N, N, N, N); ex[5] = 9'b000_1_0000_0;
    st[6] = mk(N, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[6] = 9'b000_0_0000_0;
    st[7] = mk(Y, 4'd7, 4'd7, 2'b10, 4'd0, N, N, N, N, N, N); ex[7] = 9'b000_1_1000_0;
    st[8] = mk(N, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[8] = 9'b000_0_0000_0;
    do_reset();
    for (int s = 0; s < 9; s++) begin
      drive(st[s]);
      exp_q.push_back(ex[s][5:0]);
      #1;
      n_total++;
      if ({stall_IM_ID, flush, load_use_hazard} !== ex[s][8:6])
        $display("FAIL bypass comb step %0d: stall/flush/luh got %b want %b", s,
                 {stall_IM_ID, flush, load_use_hazard}, ex[s][8:6]);
      else n_pass++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({issue_ID_EX, byp_ID_EX, halted} !== e)
        $display("FAIL bypass reg step %0d: issue/byp/halted got %b want %b", s,
                 {issue_ID_EX, byp_ID_EX, halted}, e);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    stim_t st[9]; logic [8:0] ex[9]; logic [5:0] e;
    st[0] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, Y, Y, N); ex[0] = 9'b010_0_0000_0;
    st[1] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, Y, N, N); ex[1] = 9'b010_0_0000_0;
    st[2] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[2] = 9'b000_1_0000_0;
    st[3] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd3, Y, Y, N, N, N, N); ex[3] = 9'b000_1_0000_0;
    st[4] = mk(Y, 4'd3, 4'd0, 2'b01, 4'd0, N, N, N, N, Y, N); ex[4] = 9'b010_0_0000_0;
    st[5] = mk(Y, 4'd3, 4'd0, 2'b01, 4'd0, N, N, N, N, Y, N); ex[5] = 9'b010_0_0000_0;
    st[6] = mk(Y, 4'd3, 4'd0, 2'b01, 4'd0, N, N, N, N, N, N); ex[6] = 9'b010_0_0000_0;
    st[7] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[7] = 9'b000_1_0000_0;
    st[8] = mk(N, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[8] = 9'b000_0_0000_0;
    do_reset();
    for (int s = 0; s < 9; s++) begin
      drive(st[s]);
      exp_q.push_back(ex[s][5:0]);
      #1;
      n_total++;
      if ({stall_IM_ID, flush, load_use_hazard} !== ex[s][8:6])
        $display("FAIL flush comb step %0d: stall/flush/luh got %b want %b", s,
                 {stall_IM_ID, flush, load_use_hazard}, ex[s][8:6]);
      else n_pass++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({issue_ID_EX, byp_ID_EX, halted} !== e)
        $display("FAIL flush reg step %0d: issue/byp/halted got %b want %b", s,
                 {issue_ID_EX, byp_ID_EX, halted}, e);
      else n_pass++;
    end
  endtask

  task automatic test_multicycle();
    stim_t st[9]; logic [8:0] ex[9]; logic [5:0] e;
    st[0] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd1, Y, N, Y, N, N, N); ex[0] = 9'b100_1_0000_0;
    st[1] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd1, Y, N, Y, N, N, N); ex[1] = 9'b100_0_0000_0;
    st[2] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd1, Y, N, Y, N, N, N); ex[2] = 9'b000_0_0000_0;
    st[3] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[3] = 9'b000_1_0000_0;
    st[4] = mk(N, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[4] = 9'b000_0_0000_0;
    st[5] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd1, Y, N, Y, N, N, N); ex[5] = 9'b100_1_0000_0;
    st[6] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd1, Y, N, Y, N, N, Y); ex[6] = 9'b100_0_0000_0;
    st[7] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[7] = 9'b000_1_0000_0;
    st[8] = mk(N, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[8] = 9'b000_0_0000_0;
    do_reset();
    for (int s = 0; s < 9; s++) begin
      drive(st[s]);
      exp_q.push_back(ex[s][5:0]);
      #1;
      n_total++;
      if ({stall_IM_ID, flush, load_use_hazard} !== ex[s][8:6])
        $display("FAIL multicycle comb step %0d: stall/flush/luh got %b want %b", s,
                 {stall_IM_ID, flush, load_use_hazard}, ex[s][8:6]);
      else n_pass++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({issue_ID_EX, byp_ID_EX, halted} !== e)
        $display("FAIL multicycle reg step %0d: issue/byp/halted got %b want %b", s,
                 {issue_ID_EX, byp_ID_EX, halted}, e);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    stim_t st[6]; logic [8:0] ex[6]; logic [5:0] e;
    st[0] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, Y, N, N); ex[0] = 9'b000_1_0000_1;
    st[1] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[1] = 9'b100_0_0000_1;
    st[2] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[2] = 9'b100_0_0000_1;
    st[3] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, Y); ex[3] = 9'b100_0_0000_0;
    st[4] = mk(Y, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[4] = 9'b000_1_0000_0;
    st[5] = mk(N, 4'd0, 4'd0, 2'b00, 4'd0, N, N, N, N, N, N); ex[5] = 9'b000_0_0000_0;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      drive(st[s]);
      exp_q.push_back(ex[s][5:0]);
      #1;
      n_total++;
      if ({stall_IM_ID, flush, load_use_hazard} !== ex[s][8:6])
        $display("FAIL halt comb step %0d: stall/flush/luh got %b want %b", s,
                 {stall_IM_ID, flush, load_use_hazard}, ex[s][8:6]);
      else n_pass++;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_total++;
      if ({issue_ID_EX, byp_ID_EX, halted} !== e)
        $display("FAIL halt reg step %0d: issue/byp/halted got %b want %b", s,
                 {issue_ID_EX, byp_ID_EX, halted}, e);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_bypass();
    test_flush();
    test_multicycle();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
